// File: rtl/xlr8_uart_rx_mon.sv
// 8N1 serial receiver for the board TXD line: oversampled, mid-bit majority vote,
// first-word-fall-through byte FIFO and sticky framing/overflow flags.
module xlr8_uart_rx_mon #(
   parameter int BIT_CLKS    = 139,
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   input  logic       clr_err,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overflow,
   output logic [4:0] fifo_count,
   output logic       busy
);

   localparam int CNT_W = $clog2(BIT_CLKS);
   localparam int HALF  = BIT_CLKS / 2;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   function automatic logic maj3(input logic [2:0] h);
      return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic [2:0]             hist_q;
   logic                   rxs;
   logic                   vote;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             push, ferr_set, cnt_half, cnt_last;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             full, pop, do_push, drop;
   logic             frame_err_q, overflow_q;

   // Line synchronizer and 3-sample vote history
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '1;
         hist_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
         hist_q <= {hist_q[1:0], rxs};
      end
   end

   assign rxs      = sync_q[SYNC_STAGES-1];
   assign vote     = maj3(hist_q);
   assign cnt_half = (cnt_q == CNT_HALF);
   assign cnt_last = (cnt_q == CNT_LAST);

   // Frame state machine
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      if (state_q != IDLE && state_q != WAIT_IDLE)
         cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (hist_q[0] && !rxs) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_half && vote) begin
               state_d = IDLE;
            end else if (cnt_last) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (cnt_half)
               shift_d = {vote, shift_q[7:1]};
            if (cnt_last) begin
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 1'b1;
            end
         end
         STOP: begin
            // Leaving at mid-stop lets IDLE catch a back-to-back start edge.
            if (cnt_half) begin
               if (vote) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rxs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte FIFO
   assign full    = (count_q == CNT_FULL);
   assign pop     = rx_valid & rx_ready;
   assign do_push = push & (~full | pop);
   assign drop    = push & full & ~pop;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         frame_err_q <= ferr_set | (frame_err_q & ~clr_err);
         overflow_q  <= drop | (overflow_q & ~clr_err);
      end
   end

   assign rx_valid   = (count_q != '0);
   assign rx_data    = rx_valid ? mem[rd_ptr_q] : 8'h00;
   assign frame_err  = frame_err_q;
   assign overflow   = overflow_q;
   assign fifo_count = 5'(count_q);
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_xlr8_uart_rx_mon.sv
// Directed bench for xlr8_uart_rx_mon with BIT_CLKS=16: frame table plus
// back-to-back, false start, framing error, overflow and mid-frame reset sequences.
module tb_xlr8_uart_rx_mon;
   localparam int B    = 16;
   localparam int H    = B / 2;
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rxd = 1'b1;
   logic       clr_err = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overflow;
   logic [4:0] fifo_count;
   logic       busy;

   xlr8_uart_rx_mon #(.BIT_CLKS(B), .FIFO_DEPTH(8), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rstn(rstn), .rxd(rxd), .clr_err(clr_err), .rx_ready(rx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
      .overflow(overflow), .fifo_count(fifo_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;
   logic [7:0] got[$];

   // Record every byte the consumer takes
   always @(negedge clk) begin
      if (rstn && rx_valid && rx_ready) got.push_back(rx_data);
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_ferr;
   } vec_t;
   vec_t vt[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (B) tick();
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (B) tick();
      end
      rxd = stop;
      repeat (B) tick();
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   function automatic logic [7:0] got_at(input int i);
      return (i < got.size()) ? got[i] : 8'hxx;
   endfunction

   initial begin
      vt[0] = '{8'h00, 1'b1, 1'b0};
      vt[1] = '{8'hFF, 1'b1, 1'b0};
      vt[2] = '{8'h80, 1'b1, 1'b0};
      vt[3] = '{8'h01, 1'b1, 1'b0};
      vt[4] = '{8'h5A, 1'b0, 1'b1};
      vt[5] = '{8'hC3, 1'b1, 1'b0};
      vt[6] = '{8'h96, 1'b1, 1'b0};

      repeat (3) tick();
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovf", overflow, 0);
      rstn = 1'b1;
      repeat (4) tick();

      // Single-frame table
      rx_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         got.delete();
         send_byte(vt[v].data, vt[v].stop);
         rxd = 1'b1;
         repeat (2 * B) tick();
         chk($sformatf("vec%0d_npop", v), got.size(), vt[v].exp_ferr ? 0 : 1);
         if (!vt[v].exp_ferr) chk($sformatf("vec%0d_data", v), got_at(0), vt[v].data);
         chk($sformatf("vec%0d_ferr", v), frame_err, vt[v].exp_ferr);
         chk($sformatf("vec%0d_count", v), fifo_count, 0);
         pulse_clr();
         chk($sformatf("vec%0d_clr", v), frame_err, 0);
      end

      // Back-to-back frames
      got.delete();
      send_byte(8'h55, 1'b1);
      send_byte(8'hA3, 1'b1);
      repeat (2 * B) tick();
      chk("b2b_npop", got.size(), 2);
      chk("b2b_first", got_at(0), 8'h55);
      chk("b2b_second", got_at(1), 8'hA3);
      chk("b2b_ferr", frame_err, 0);
      chk("b2b_ovf", overflow, 0);
      chk("b2b_count", fifo_count, 0);

      // False start: 3-clock glitch
      got.delete();
      rxd = 1'b0;
      repeat (3) tick();
      rxd = 1'b1;
      tick();
      chk("glitch_busy_on", busy, 1);
      repeat (H + SYNC + 3 - 4) tick();
      chk("glitch_busy_off", busy, 0);
      repeat (10 * B) tick();
      chk("glitch_npop", got.size(), 0);
      chk("glitch_ferr", frame_err, 0);

      // Framing error followed by line break, then a good frame
      rx_ready = 1'b0;
      send_byte(8'h3C, 1'b0);
      repeat (40) tick();
      chk("brk_busy", busy, 1);
      chk("brk_ferr", frame_err, 1);
      rxd = 1'b1;
      repeat (B) tick();
      chk("brk_idle", busy, 0);
      chk("brk_count0", fifo_count, 0);
      send_byte(8'h81, 1'b1);
      repeat (B) tick();
      chk("brk_count1", fifo_count, 1);
      chk("brk_data", rx_data, 8'h81);
      chk("brk_ferr_hold", frame_err, 1);
      pulse_clr();
      chk("brk_ferr_clr", frame_err, 0);
      got.delete();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      chk("brk_pop", got_at(0), 8'h81);
      chk("brk_empty", fifo_count, 0);

      // Overflow with consumer stalled, then drain
      for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
      repeat (4) tick();
      chk("ovf_count", fifo_count, 8);
      chk("ovf_flag", overflow, 1);
      got.delete();
      rx_ready = 1'b1;
      repeat (12) tick();
      rx_ready = 1'b0;
      chk("drain_n", got.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("drain%0d", i), got_at(i), 8'(i + 1));
      chk("drain_count", fifo_count, 0);
      pulse_clr();
      chk("ovf_clr", overflow, 0);

      // Full FIFO, pop on the exact push cycle
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
      chk("full_count", fifo_count, 8);
      got.delete();
      fork
         send_byte(8'h09, 1'b1);
         begin
            repeat (9 * B + H + 3) tick();
            chk("edge_pre_count", fifo_count, 8);
            chk("edge_pre_head", rx_data, 8'h01);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
            chk("edge_count", fifo_count, 8);
            chk("edge_ovf", overflow, 0);
            chk("edge_head", rx_data, 8'h02);
         end
      join
      chk("edge_popped", got_at(0), 8'h01);
      got.delete();
      rx_ready = 1'b1;
      repeat (12) tick();
      rx_ready = 1'b0;
      chk("edge_drain_n", got.size(), 8);
      chk("edge_drain_last", got_at(7), 8'h09);
      chk("edge_drain_count", fifo_count, 0);

      // Reset during DATA bit 4 with two bytes queued
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      chk("mid_count", fifo_count, 2);
      rxd = 1'b0;
      repeat (B) tick();
      for (int i = 0; i < 4; i++) begin
         rxd = 1'(8'hC6 >> i);
         repeat (B) tick();
      end
      rxd = 1'(8'hC6 >> 4);
      repeat (7) tick();
      chk("mid_busy", busy, 1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", rx_valid, 0);
      chk("mid_rst_data", rx_data, 0);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_flags", {frame_err, overflow}, 0);
      rxd = 1'b1;
      repeat (3) tick();
      rstn = 1'b1;
      repeat (2 * B) tick();
      fork
         send_byte(8'h7E, 1'b1);
         begin
            int n = 0;
            while (!rx_valid && n < 300) begin
               tick();
               n++;
            end
            chk("lat_window", (n >= 9 * B + H + 1) && (n <= 9 * B + H + SYNC + 3), 1);
         end
      join
      chk("post_data", rx_data, 8'h7E);
      chk("post_count", fifo_count, 1);
      chk("post_ferr", frame_err, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
